// File: rtl/regfile_writer_pkg.sv
// Shared constants and the write-back entry type for the register-file writer.
package regfile_writer_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writer_wb_fifo.sv
// Synchronous FIFO for memory write-back results.
// Also exposes a mask of the destination registers held in valid entries.
module wb_fifo
    import regfile_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [AW:0]      count,
    output logic [NREGS-1:0] pending
);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        pending = '0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rd_ptr;
            if ({1'b0, offset} < count) begin
                pending[mem[i].rd] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_writer.sv
// Register-file write-back front end: merges ALU results with queued memory
// results into one registered write per cycle, ALU taking priority.
module regfile_writer
    import regfile_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic              mem_ready,
    output logic              wr,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   indata,
    output logic [NREGS-1:0]  pending,
    output logic [AW:0]       fifo_count
);

    wb_entry_t head;
    wb_entry_t push_entry;
    logic      can_accept;
    logic      alu_fire;
    logic      push;
    logic      pop;

    // A full FIFO also stalls the ALU so the head is guaranteed to drain.
    assign can_accept = !rst && (fifo_count < (AW+1)'(DEPTH));
    assign alu_ready  = can_accept;
    assign mem_ready  = can_accept;

    assign alu_fire   = alu_valid && can_accept;
    assign push       = mem_valid && can_accept;
    assign pop        = !rst && !alu_fire && (fifo_count != '0);
    assign push_entry = '{rd: mem_rd, data: mem_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .pending    (pending)
    );

    // Writes to x0 still consume their slot but never assert wr.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr     <= 1'b0;
            rd     <= '0;
            indata <= '0;
        end else if (alu_fire) begin
            wr     <= (alu_rd != '0);
            rd     <= alu_rd;
            indata <= alu_data;
        end else if (pop) begin
            wr     <= (head.rd != '0);
            rd     <= head.rd;
            indata <= head.data;
        end else begin
            wr     <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_writer.md
Name: regfile_writer

Overview:
- Write-back front end for the 32x32 register file; drives its wr/rd/indata write port.
- Merges two result producers into one registered write per cycle:
  - single-cycle ALU results;
  - multi-cycle load/memory results, buffered in a small FIFO.
- Exposes a pending-write mask so decode can stall on registers with queued writes.

Parameters:
- DEPTH, 4, memory-result FIFO entries (power of 2, >=2)
- AW, 2, FIFO pointer width, log2(DEPTH)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-high reset
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_ready  output  1  ALU result accepted when alu_valid&&alu_ready
- mem_valid  input  1  memory result present
- mem_rd  input  5  memory destination register
- mem_data  input  32  memory result
- mem_ready  output  1  memory result accepted when mem_valid&&mem_ready
- wr  output  1  register-file write enable (registered)
- rd  output  5  register-file write address (registered)
- indata  output  32  register-file write data (registered)
- pending  output  32  bit i set when a queued FIFO entry targets register i; bit 0 always 0
- fifo_count  output  AW+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at posedge):
  - wr=0, rd=0, indata=0.
  - FIFO pointers and count cleared; pending=0.
  - Any in-flight handshake is discarded.
  - While rst is high, alu_ready=0 and mem_ready=0.
- Ready generation (combinational from registered count):
  - mem_ready = !rst && (count<DEPTH).
  - alu_ready = !rst && (count<DEPTH).
  - A full FIFO back-pressures the ALU so the FIFO can drain (starvation guard).
- Memory accept: mem_valid&&mem_ready pushes {mem_rd, mem_data} at the tail on that posedge.
- Arbitration, one write slot per cycle, evaluated in this order:
  1. alu_valid&&alu_ready: issue the ALU result.
  2. Else, if count>0: pop the FIFO head and issue it.
  3. Else: no issue.
- Issue latency:
  - The selected result appears on wr/rd/indata at the next posedge: one cycle after accept for the ALU, one cycle after pop for the FIFO.
  - wr stays high for exactly one cycle per write.
  - With no issue, wr=0; rd and indata hold their previous values.
- x0 handling:
  - Results with rd==0 are accepted and consumed as normal (FIFO pops, ready unaffected).
  - wr is forced to 0 for that slot.
- Simultaneous push and pop in one cycle: count unchanged; both pointers advance.
  - The push is allowed only if count<DEPTH before the edge; a pop does not open a same-cycle slot.
- Full FIFO (count==DEPTH):
  - Both readies are 0.
  - The head pops every cycle until count<DEPTH.
- Empty FIFO (count==0) with alu_valid=0: idle, wr=0.
- Pointer wrap-around: AW-bit pointers wrap naturally; count is tracked separately (AW+1 bits).
- Ordering:
  - Memory results are written in arrival order.
  - There is no ordering guarantee between the ALU and memory ports; the issue stage must not send a same-rd WAW across ports while pending[rd]=1.
- pending:
  - Combinational OR over valid FIFO entries of the one-hot decode of the entry's rd.
  - Does not include the entry currently being driven on wr/rd.

Decomposition:
- Shared package: REG_AW=5, XLEN=32, NREGS=32 constants, and the {rd,data} write-back entry typedef.
- One sub-module: wb_fifo (DEPTH-entry synchronous FIFO with push/pop/count and entry visibility for pending).
- Arbitration and output registers stay in regfile_writer.

Test Plan:
- Reset: hold rst 2 cycles with alu_valid=1 and mem_valid=1 -> wr=0, rd=0, indata=0, pending=0, fifo_count=0, both readies 0; after release both readies 1.
- ALU only: alu_rd=5, alu_data=0xDEADBEEF for one cycle -> next cycle wr=1, rd=5, indata=0xDEADBEEF; following cycle wr=0.
- Contention:
  - Stimulus: mem pushes rd=7/0x11 and rd=8/0x22, while the ALU sends rd=3/0x33 on three consecutive cycles.
  - Response: writes in order 3,3,3, then 7/0x11, then 8/0x22.
  - pending shows bits 7,8 until each pops.
- Full FIFO:
  - Stimulus: ALU continuously valid; fill FIFO with 4 mem entries.
  - Response: fifo_count=4, alu_ready=0 and mem_ready=0 while full; the FIFO drains one entry, then alu_ready returns to 1.
- x0 drop: mem_rd=0, data=0xFFFFFFFF -> entry popped, fifo_count decrements, wr stays 0.
- Reset mid-operation: FIFO holding 3 entries, assert rst -> next cycle fifo_count=0, pending=0, no write of the queued entries ever appears.
